// File: rtl/sigma_io_pkg.sv
// Shared types and sizing helpers for the sigma board input front end.
// Holds default debounce constants and counter-width functions.
package sigma_io_pkg;

  localparam int N_SW_DFLT         = 16;
  localparam int TICK_DIV_DFLT     = 1000;
  localparam int STABLE_TICKS_DFLT = 10;

  typedef logic [N_SW_DFLT-1:0] sw_vec_t;

  function automatic int tick_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

  function automatic int cnt_w(input int ticks);
    return $clog2(ticks) + 1;
  endfunction

endpackage

// File: rtl/sigma_debounce_ch.sv
// One debounced channel: 2-FF synchroniser, persistence counter
// and accepted (stable) level.
module sigma_debounce_ch
  import sigma_io_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DFLT
) (
  input  logic clk_i,
  input  logic srstn_i,
  input  logic pin_i,
  input  logic tick_i,
  output logic stab_o
);

  localparam int CW = cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stab;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_stab  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= pin_i;
      r_sync2 <= r_sync1;
      // any return to the accepted level cancels the pending change
      if (r_sync2 == r_stab) begin
        r_cnt <= '0;
      end else if (tick_i) begin
        if (r_cnt == LAST) begin
          r_stab <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign stab_o = r_stab;

endmodule

// File: rtl/sigma_input_conditioner.sv
// Button/switch input conditioner: sync, debounce, edge IRQ, change pulse.
// Define SIGMA_INCOND_IRQ_LATCH_EN for a held IRQ cleared by irq_ack_i.
module sigma_input_conditioner
  import sigma_io_pkg::*;
#(
  parameter int N_SW         = N_SW_DFLT,
  parameter int TICK_DIV     = TICK_DIV_DFLT,
  parameter int STABLE_TICKS = STABLE_TICKS_DFLT
) (
  input  logic            clk_i,
  input  logic            srstn_i,
  input  logic            btn_pin_i,
  input  logic [N_SW-1:0] sw_pin_i,
  output logic            btn_o,
  output logic [N_SW-1:0] sw_o,
  output logic            btn_irq_o,
  output logic            sw_chg_o
`ifdef SIGMA_INCOND_IRQ_LATCH_EN
  ,
  input  logic            irq_ack_i
`endif
);

  localparam int TW = tick_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic            w_btn_stab;
  logic [N_SW-1:0] w_sw_stab;
  logic            w_btn_rise;
  logic            r_btn_prev;
  logic [N_SW-1:0] r_sw_prev;
  logic            r_sw_chg;
  logic            r_btn_irq;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  sigma_debounce_ch #(
    .STABLE_TICKS(STABLE_TICKS)
  ) u_btn (
    .clk_i  (clk_i),
    .srstn_i(srstn_i),
    .pin_i  (btn_pin_i),
    .tick_i (w_tick),
    .stab_o (w_btn_stab)
  );

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    sigma_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_sw (
      .clk_i  (clk_i),
      .srstn_i(srstn_i),
      .pin_i  (sw_pin_i[g]),
      .tick_i (w_tick),
      .stab_o (w_sw_stab[g])
    );
  end

  assign w_btn_rise = w_btn_stab & ~r_btn_prev;

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      r_btn_prev <= 1'b0;
      r_sw_prev  <= '0;
      r_sw_chg   <= 1'b0;
      r_btn_irq  <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_stab;
      r_sw_prev  <= w_sw_stab;
      r_sw_chg   <= |(w_sw_stab ^ r_sw_prev);
`ifdef SIGMA_INCOND_IRQ_LATCH_EN
      // a new edge beats a simultaneous ack
      if (w_btn_rise) begin
        r_btn_irq <= 1'b1;
      end else if (irq_ack_i) begin
        r_btn_irq <= 1'b0;
      end
`else
      r_btn_irq <= w_btn_rise;
`endif
    end
  end

  assign btn_o     = w_btn_stab;
  assign sw_o      = w_sw_stab;
  assign btn_irq_o = r_btn_irq;
  assign sw_chg_o  = r_sw_chg;

endmodule

// File: tb/tb_sigma_input_conditioner.sv
// Self-checking bench for sigma_input_conditioner (TICK_DIV=4, STABLE_TICKS=3).
// Build with SIGMA_INCOND_IRQ_LATCH_EN defined to cover the held-IRQ variant.
module tb_sigma_input_conditioner;

  logic        clk;
  logic        srstn;
  logic        btn_pin;
  logic [15:0] sw_pin;
  logic        btn_o;
  logic [15:0] sw_o;
  logic        btn_irq_o;
  logic        sw_chg_o;
  logic        irq_ack;

  int tests;
  int fails;

  logic [15:0] sw_q[$];
  logic        irq_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sigma_input_conditioner #(
    .N_SW        (16),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk_i    (clk),
    .srstn_i  (srstn),
    .btn_pin_i(btn_pin),
    .sw_pin_i (sw_pin),
    .btn_o    (btn_o),
    .sw_o     (sw_o),
    .btn_irq_o(btn_irq_o),
    .sw_chg_o (sw_chg_o)
`ifdef SIGMA_INCOND_IRQ_LATCH_EN
    ,
    .irq_ack_i(irq_ack)
`endif
  );

  task automatic test_reset();
    srstn   = 1'b0;
    btn_pin = 1'b1;
    sw_pin  = 16'hFFFF;
    irq_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({btn_o, sw_o, btn_irq_o, sw_chg_o} !== 19'd0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got %b, want 0", i,
                 {btn_o, sw_o, btn_irq_o, sw_chg_o});
      end
    end
    srstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({btn_o, sw_o, btn_irq_o, sw_chg_o} !== 19'd0) begin
        fails++;
        $display("FAIL reset_release cyc%0d: got %b, want 0", i,
                 {btn_o, sw_o, btn_irq_o, sw_chg_o});
      end
    end
    btn_pin = 1'b0;
    sw_pin  = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({btn_o, sw_o, btn_irq_o, sw_chg_o} !== 19'd0) begin
        fails++;
        $display("FAIL reset_settle cyc%0d: got %b, want 0", i,
                 {btn_o, sw_o, btn_irq_o, sw_chg_o});
      end
    end
  endtask

  task automatic test_sw_level();
    int n;
    int pulses;
    logic [15:0] exp;
    sw_pin = 16'h00A5;
    sw_q.push_back(16'h00A5);
    n = 0;
    pulses = 0;
    while (sw_o !== 16'h00A5 && n < 20) begin
      @(negedge clk);
      n++;
      if (sw_chg_o === 1'b1) pulses++;
    end
    tests++;
    if (n < 11 || n > 14) begin
      fails++;
      $display("FAIL sw_latency: got %0d cycles, want 11..14", n);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sw_chg_o === 1'b1) begin
        pulses++;
        if (sw_q.size() > 0) begin
          exp = sw_q.pop_front();
          tests++;
          if (sw_o !== exp) begin
            fails++;
            $display("FAIL sw_value: got %h, want %h", sw_o, exp);
          end
        end
      end
      if (i == 0) begin
        tests++;
        if (sw_chg_o !== 1'b1) begin
          fails++;
          $display("FAIL sw_chg_timing: got %b, want 1", sw_chg_o);
        end
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL sw_chg_count: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_btn_glitch();
    int highs;
    btn_pin = 1'b1;
    repeat (3) @(negedge clk);
    btn_pin = 1'b0;
    highs = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (btn_o !== 1'b0 || btn_irq_o !== 1'b0) highs++;
    end
    tests++;
    if (highs != 0) begin
      fails++;
      $display("FAIL btn_glitch: got %0d active cycles, want 0", highs);
    end
  endtask

  task automatic test_btn_press();
    int rise;
    int bad;
    logic exp;
    btn_pin = 1'b1;
    irq_q.push_back(1'b1);
    rise = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (btn_o === 1'b1 && rise == 0) rise = c;
      if (rise != 0 && c == rise + 1 && irq_q.size() > 0) begin
        exp = irq_q.pop_front();
        tests++;
        if (btn_irq_o !== exp) begin
          fails++;
          $display("FAIL btn_irq_set: got %b, want %b", btn_irq_o, exp);
        end
      end
      if (rise != 0 && c == rise + 2) begin
        tests++;
`ifdef SIGMA_INCOND_IRQ_LATCH_EN
        if (btn_irq_o !== 1'b1) begin
          fails++;
          $display("FAIL btn_irq_held: got %b, want 1", btn_irq_o);
        end
`else
        if (btn_irq_o !== 1'b0) begin
          fails++;
          $display("FAIL btn_irq_width: got %b, want 0", btn_irq_o);
        end
`endif
      end
    end
    tests++;
    if (rise < 11 || rise > 14) begin
      fails++;
      $display("FAIL btn_latency: got %0d cycles, want 11..14", rise);
    end
    btn_pin = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
`ifdef SIGMA_INCOND_IRQ_LATCH_EN
      if (btn_irq_o !== 1'b1) bad++;
`else
      if (btn_irq_o !== 1'b0) bad++;
`endif
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL btn_fall_irq: got %0d wrong cycles, want 0", bad);
    end
    tests++;
    if (btn_o !== 1'b0) begin
      fails++;
      $display("FAIL btn_fall_level: got %b, want 0", btn_o);
    end
  endtask

`ifdef SIGMA_INCOND_IRQ_LATCH_EN
  task automatic test_irq_ack();
    int n;
    int bad;
    btn_pin = 1'b1;
    n = 0;
    while (btn_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (btn_o !== 1'b1) begin
      fails++;
      $display("FAIL ack_rise_timeout: got %b, want 1", btn_o);
    end
    irq_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (btn_irq_o !== 1'b1) begin
      fails++;
      $display("FAIL ack_vs_set: got %b, want 1", btn_irq_o);
    end
    @(negedge clk);
    irq_ack = 1'b0;
    tests++;
    if (btn_irq_o !== 1'b0) begin
      fails++;
      $display("FAIL ack_clear: got %b, want 0", btn_irq_o);
    end
    btn_pin = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      irq_ack = (i == 20);
      if (btn_irq_o !== 1'b0) bad++;
    end
    irq_ack = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL ack_idle: got %0d active cycles, want 0", bad);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    int pulses;
    logic [15:0] exp;
    sw_pin = 16'h5A00;
    repeat (8) @(negedge clk);
    tests++;
    if (sw_o !== 16'h00A5) begin
      fails++;
      $display("FAIL mid_pre: got %h, want 00a5", sw_o);
    end
    srstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({btn_o, sw_o, btn_irq_o, sw_chg_o} !== 19'd0) begin
        fails++;
        $display("FAIL mid_reset cyc%0d: got %b, want 0", i,
                 {btn_o, sw_o, btn_irq_o, sw_chg_o});
      end
    end
    srstn = 1'b1;
    sw_q.push_back(16'h5A00);
    n = 0;
    pulses = 0;
    while (sw_o !== 16'h5A00 && n < 20) begin
      @(negedge clk);
      n++;
      if (sw_chg_o === 1'b1) pulses++;
    end
    tests++;
    if (n < 11 || n > 14) begin
      fails++;
      $display("FAIL mid_latency: got %0d cycles, want 11..14", n);
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL mid_early_chg: got %0d pulses, want 0", pulses);
    end
    @(negedge clk);
    tests++;
    if (sw_chg_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_chg: got %b, want 1", sw_chg_o);
    end else if (sw_q.size() > 0) begin
      exp = sw_q.pop_front();
      tests++;
      if (sw_o !== exp) begin
        fails++;
        $display("FAIL mid_value: got %h, want %h", sw_o, exp);
      end
    end
    @(negedge clk);
    tests++;
    if (sw_chg_o !== 1'b0) begin
      fails++;
      $display("FAIL mid_chg_width: got %b, want 0", sw_chg_o);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sw_level();
    test_btn_glitch();
    test_btn_press();
`ifdef SIGMA_INCOND_IRQ_LATCH_EN
    test_irq_ack();
`endif
    test_reset_mid();
    tests++;
    if (sw_q.size() != 0 || irq_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: got %0d/%0d, want 0/0",
               sw_q.size(), irq_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
